// File: rtl/jt51_lfsr_pkg.sv
// Shared definitions for the jt51 LFSR noise bank.
//   - Advance-mode constants (toggle / rising edge / free-running).
//   - Default feedback mask, channel-0 seed and per-channel seed spread.
//   - chan_seed(): derives a channel's reset seed from the bank parameters.
package jt51_lfsr_pkg;

    localparam int unsigned LFSR_TOGGLE = 0;  // advance on any base change
    localparam int unsigned LFSR_RISE   = 1;  // advance on base rising edge only
    localparam int unsigned LFSR_FREE   = 2;  // advance on every enabled clock

    localparam logic [31:0] DEFAULT_TAPS     = 32'h0006_C003;
    localparam logic [31:0] DEFAULT_INIT     = 32'd220;
    localparam logic [31:0] DEFAULT_SEED_XOR = 32'h0000_0100;

    function automatic logic [31:0] width_mask(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    // Seeds differ per channel so channels never run in lockstep; a spread that
    // lands on zero would lock the register, so it falls back to INIT.
    function automatic logic [31:0] chan_seed(input logic [31:0] init,
                                              input logic [31:0] seed_xor,
                                              input int unsigned c,
                                              input int unsigned w);
        logic [31:0] s;
        s = (init ^ (c * seed_xor)) & width_mask(w);
        return (s == 32'h0) ? (init & width_mask(w)) : s;
    endfunction

endpackage

// File: rtl/jt51_lfsr_cell.sv
// One Fibonacci LFSR channel.
// Ports:
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   clk_en_i  enable for edge detector, lock check and advance
//   base_i    base timing input for this channel
//   ld_i      seed load for this channel (already decoded), ignores clk_en_i
//   ld_val_i  value to load; zero is refused and replaced by SEED
//   bb_o      full register state
//   lock_o    sticky flag: zero state seen or zero load refused
module jt51_lfsr_cell
    import jt51_lfsr_pkg::*;
#(
    parameter int unsigned W    = 19,
    parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS),
    parameter logic [W-1:0] SEED = W'(DEFAULT_INIT),
    parameter int unsigned MODE = LFSR_TOGGLE
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clk_en_i,
    input  logic         base_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] bb_o,
    output logic         lock_o
);

    logic [W-1:0] bb_q, bb_d;
    logic         last_q, last_d;
    logic         lock_q, lock_d;
    logic         adv;
    logic         fb;

    always_comb begin
        fb = ^(bb_q & TAPS);
        if (MODE == LFSR_FREE) begin
            adv = 1'b1;
        end else if (MODE == LFSR_RISE) begin
            adv = base_i & ~last_q;
        end else begin
            adv = base_i ^ last_q;
        end
    end

    always_comb begin
        bb_d   = bb_q;
        last_d = last_q;
        lock_d = lock_q;
        if (clk_en_i) begin
            last_d = base_i;
        end
        // A load takes priority and swallows any advance in the same cycle.
        if (ld_i) begin
            if (ld_val_i == '0) begin
                bb_d   = SEED;
                lock_d = 1'b1;
            end else begin
                bb_d = ld_val_i;
            end
        end else if (clk_en_i) begin
            if (bb_q == '0) begin
                bb_d   = SEED;
                lock_d = 1'b1;
            end else if (adv) begin
                bb_d = {bb_q[W-2:0], fb};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bb_q   <= SEED;
            last_q <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            bb_q   <= bb_d;
            last_q <= last_d;
            lock_q <= lock_d;
        end
    end

    assign bb_o   = bb_q;
    assign lock_o = lock_q;

endmodule

// File: rtl/jt51_lfsr_bank.sv
// Bank of CH independent LFSR noise generators for the LFO/noise path.
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset
//   clk_en    clock enable for advances / edge detect / lock checks
//   base      per-channel base timing inputs
//   ld        seed-load strobe; ld_ch selects channel, ld_val the value
//   ld_ack    one-cycle pulse the clock after a load is sampled
//   rd_ch     channel for the registered parallel read
//   rd_val    state of rd_ch, one clock latency; zero for rd_ch >= CH
//   out       MSB of every channel
//   lock_err  sticky per-channel lock-up flags
module jt51_lfsr_bank
    import jt51_lfsr_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned W        = 19,
    parameter logic [31:0] TAPS     = DEFAULT_TAPS,
    parameter logic [31:0] INIT     = DEFAULT_INIT,
    parameter logic [31:0] SEED_XOR = DEFAULT_SEED_XOR,
    parameter int unsigned MODE     = LFSR_TOGGLE
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_en,
    input  logic [CH-1:0]                          base,
    input  logic                                   ld,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ld_ch,
    input  logic [W-1:0]                           ld_val,
    output logic                                   ld_ack,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] rd_ch,
    output logic [W-1:0]                           rd_val,
    output logic [CH-1:0]                          out,
    output logic [CH-1:0]                          lock_err
);

    logic [W-1:0]  bb [CH];
    logic [CH-1:0] ld_sel;
    logic          ld_ack_q, ld_ack_d;
    logic [W-1:0]  rd_val_q, rd_val_d;

    // Loads to a channel number past CH select nothing but are still acked.
    always_comb begin
        ld_sel = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (ld && (32'(ld_ch) == c)) begin
                ld_sel[c] = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam logic [W-1:0] SeedC = W'(chan_seed(INIT, SEED_XOR, c, W));

        jt51_lfsr_cell #(
            .W    (W),
            .TAPS (TAPS[W-1:0]),
            .SEED (SeedC),
            .MODE (MODE)
        ) u_cell (
            .clk_i    (clk),
            .rst_ni   (rst),
            .clk_en_i (clk_en),
            .base_i   (base[c]),
            .ld_i     (ld_sel[c]),
            .ld_val_i (ld_val),
            .bb_o     (bb[c]),
            .lock_o   (lock_err[c])
        );

        assign out[c] = bb[c][W-1];
    end

    always_comb begin
        ld_ack_d = ld;
        rd_val_d = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (32'(rd_ch) == c) begin
                rd_val_d = bb[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_ack_q <= 1'b0;
            rd_val_q <= '0;
        end else begin
            ld_ack_q <= ld_ack_d;
            rd_val_q <= rd_val_d;
        end
    end

    assign ld_ack = ld_ack_q;
    assign rd_val = rd_val_q;

endmodule

// File: tb/tb_jt51_lfsr_bank.sv
module tb_jt51_lfsr_bank;

    localparam int unsigned W = 19;
    localparam logic [18:0] TAPS_TB = 19'h6C003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic        clk_en2 = 1'b0;
    logic [3:0]  base0 = '0, base1 = '0, base2 = '0;
    logic        ld = 1'b0;
    logic [1:0]  ld_ch = '0;
    logic [18:0] ld_val = '0;
    logic        ld_off = 1'b0;
    logic [1:0]  rd_ch0 = '0, rd_ch1 = '0, rd_ch2 = '0;
    logic [18:0] zero_val = '0;

    logic        ld_ack0, ld_ack1, ld_ack2;
    logic [18:0] rd_val0, rd_val1, rd_val2;
    logic [3:0]  out0, out1, out2;
    logic [3:0]  lock0, lock1, lock2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jt51_lfsr_bank #(.CH(4), .W(W), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .base(base0), .ld(ld), .ld_ch(ld_ch),
        .ld_val(ld_val), .ld_ack(ld_ack0), .rd_ch(rd_ch0), .rd_val(rd_val0), .out(out0),
        .lock_err(lock0)
    );

    jt51_lfsr_bank #(.CH(4), .W(W), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .base(base1), .ld(ld_off), .ld_ch(ld_ch),
        .ld_val(zero_val), .ld_ack(ld_ack1), .rd_ch(rd_ch1), .rd_val(rd_val1), .out(out1),
        .lock_err(lock1)
    );

    jt51_lfsr_bank #(.CH(4), .W(W), .MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .clk_en(clk_en2), .base(base2), .ld(ld_off), .ld_ch(ld_ch),
        .ld_val(zero_val), .ld_ack(ld_ack2), .rd_ch(rd_ch2), .rd_val(rd_val2), .out(out2),
        .lock_err(lock2)
    );

    function automatic logic [18:0] lfsr_step(input logic [18:0] x);
        return {x[17:0], ^(x & TAPS_TB)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [18:0] model;

    initial begin
        // Reset
        step();
        step();
        check("rst_rd_val", 32'(rd_val0), 32'h0);
        check("rst_ld_ack", 32'(ld_ack0), 32'h0);
        check("rst_lock", 32'(lock0), 32'h0);
        check("rst_out", 32'(out0), 32'h0);
        rst = 1'b1;
        rd_ch0 = 2'd0;
        step();
        check("seed_ch0", 32'(rd_val0), 32'h000DC);
        rd_ch0 = 2'd3;
        step();
        check("seed_ch3", 32'(rd_val0), 32'h003DC);

        // 1. MODE0 single toggle, then 11 toggles in total
        clk_en = 1'b1;
        base0[0] = 1'b1;
        step();
        rd_ch0 = 2'd0;
        step();
        check("m0_one_toggle", 32'(rd_val0), 32'h001B8);
        for (int i = 0; i < 9; i++) begin
            base0[0] = ~base0[0];
            step();
        end
        check("m0_out_after10", 32'(out0[0]), 32'h0);
        base0[0] = ~base0[0];
        step();
        check("m0_out_after11", 32'(out0[0]), 32'h1);
        model = 19'h000DC;
        for (int i = 0; i < 11; i++) model = lfsr_step(model);
        step();
        check("m0_state_after11", 32'(rd_val0), 32'(model));

        // 2. MODE1 rising edge only; MODE2 free run for 5 enabled clocks
        rd_ch1 = 2'd1;
        base1[1] = 1'b1;
        step();
        base1[1] = 1'b0;
        step();
        step();
        check("m1_one_rise", 32'(rd_val1), 32'h003B8);
        clk_en2 = 1'b1;
        repeat (5) step();
        clk_en2 = 1'b0;
        rd_ch2 = 2'd0;
        step();
        check("m2_five_shifts", 32'(rd_val2), 32'h01B80);
        step();
        check("m2_frozen", 32'(rd_val2), 32'h01B80);

        // 3. Load ch2 with 0x40000
        clk_en = 1'b0;
        ld = 1'b1;
        ld_ch = 2'd2;
        ld_val = 19'h40000;
        step();
        ld = 1'b0;
        check("ld_ack_pulse", 32'(ld_ack0), 32'h1);
        rd_ch0 = 2'd2;
        step();
        check("ld_ack_clear", 32'(ld_ack0), 32'h0);
        check("ld_ch2_val", 32'(rd_val0), 32'h40000);
        check("ld_ch2_out", 32'(out0[2]), 32'h1);

        // 4. Zero load on ch3 is refused and flagged
        ld = 1'b1;
        ld_ch = 2'd3;
        ld_val = 19'h0;
        step();
        ld = 1'b0;
        check("zero_ld_ack", 32'(ld_ack0), 32'h1);
        check("zero_ld_lock", 32'(lock0), 32'h8);
        rd_ch0 = 2'd3;
        step();
        check("zero_ld_seed", 32'(rd_val0), 32'h003DC);
        step();
        check("lock_sticky", 32'(lock0), 32'h8);

        // 5. Load ch0 while ch0 and ch1 toggle in the same cycle
        clk_en = 1'b1;
        ld = 1'b1;
        ld_ch = 2'd0;
        ld_val = 19'h12345;
        base0[0] = ~base0[0];
        base0[1] = ~base0[1];
        step();
        ld = 1'b0;
        step();
        clk_en = 1'b0;
        rd_ch0 = 2'd0;
        step();
        check("ld_wins_ch0", 32'(rd_val0), 32'h12345);
        rd_ch0 = 2'd1;
        step();
        check("ch1_shifted", 32'(rd_val0), 32'h003B8);

        // 6. Reset overrides load; clk_en low freezes state
        clk_en = 1'b1;
        ld = 1'b1;
        ld_ch = 2'd1;
        ld_val = 19'h55555;
        base0 = ~base0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        ld = 1'b0;
        clk_en = 1'b0;
        check("rst_cancels_ack", 32'(ld_ack0), 32'h0);
        check("rst_clears_lock", 32'(lock0), 32'h0);
        rd_ch0 = 2'd1;
        step();
        check("rst_over_ld_ch1", 32'(rd_val0), 32'h001DC);
        rd_ch0 = 2'd2;
        step();
        check("rst_seed_ch2", 32'(rd_val0), 32'h002DC);
        rd_ch0 = 2'd0;
        base0[0] = ~base0[0];
        step();
        base0[0] = ~base0[0];
        step();
        check("en_low_frozen", 32'(rd_val0), 32'h000DC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
